// File: rtl/config_pkg.sv
// Build configuration shared across the core; store-tracking logic reads its
// outstanding-store budget and memory tag width from here.
package config_pkg;
    typedef struct packed {
        int unsigned MaxOutstandingStores;
        int unsigned MemTidWidth;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_default = '{
        MaxOutstandingStores: 32'd7,
        MemTidWidth:          32'd2
    };
endpackage

// File: rtl/outstanding_store_ctrl_pkg.sv
// Shared types and sizing helpers for the outstanding store controller.
package outstanding_store_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_e;

    // Tracking depth is capped by both the store budget and the tag space.
    function automatic int unsigned calc_limit(int unsigned max_stores, int unsigned nr_tags);
        return (max_stores < nr_tags) ? max_stores : nr_tags;
    endfunction
endpackage

// File: rtl/outstanding_store_ctrl_if.sv
// LSU-side store handshake, memory-side issue/ack and fence/status signals.
interface outstanding_store_ctrl_if
    import outstanding_store_ctrl_pkg::*;
#(
    parameter int unsigned TidW = config_pkg::cva6_cfg_default.MemTidWidth,
    parameter int unsigned CntW = $clog2(calc_limit(config_pkg::cva6_cfg_default.MaxOutstandingStores,
                                                    2**config_pkg::cva6_cfg_default.MemTidWidth) + 1)
);
    logic            st_valid_i;
    logic            st_ready_o;
    logic            mem_valid_o;
    logic            mem_ready_i;
    logic [TidW-1:0] mem_tid_o;
    logic            ack_valid_i;
    logic [TidW-1:0] ack_tid_i;
    logic            fence_i;
    logic            fence_done_o;
    logic [CntW-1:0] outstanding_o;
    logic            full_o;
    logic            empty_o;
    logic            err_o;

    modport slave (
        input  st_valid_i, mem_ready_i, ack_valid_i, ack_tid_i, fence_i,
        output st_ready_o, mem_valid_o, mem_tid_o, fence_done_o, outstanding_o,
               full_o, empty_o, err_o
    );

    modport master (
        output st_valid_i, mem_ready_i, ack_valid_i, ack_tid_i, fence_i,
        input  st_ready_o, mem_valid_o, mem_tid_o, fence_done_o, outstanding_o,
               full_o, empty_o, err_o
    );
endinterface

// File: rtl/tag_alloc_prio.sv
// Lowest-index free tag finder over the busy vector (priority encoder on ~busy).
module tag_alloc_prio #(
    parameter int unsigned NrTags = 4,
    parameter int unsigned IdxW   = 2
) (
    input  logic [NrTags-1:0] busy,
    output logic [IdxW-1:0]   idx,
    output logic              any_free
);
    always_comb begin
        idx      = '0;
        any_free = 1'b0;
        // Scan downward so the last hit, the lowest free index, wins.
        for (int i = NrTags - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                idx      = IdxW'(i);
                any_free = 1'b1;
            end
        end
    end
endmodule

// File: rtl/outstanding_store_ctrl.sv
// Tags in-flight stores, bounds how many are outstanding and drains them on fence.
module outstanding_store_ctrl
    import outstanding_store_ctrl_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_default,
    parameter int unsigned NrTags = 2**CVA6Cfg.MemTidWidth
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    outstanding_store_ctrl_if.slave   bus
);
    localparam int unsigned Limit  = calc_limit(CVA6Cfg.MaxOutstandingStores, NrTags);
    localparam int unsigned TidW   = CVA6Cfg.MemTidWidth;
    localparam int unsigned CntW   = $clog2(Limit + 1);
    localparam logic [CntW-1:0] LimitC = CntW'(Limit);

    logic [NrTags-1:0] busy_q, busy_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    drain_state_e      state_q, state_d;
    logic              err_q;
    logic [TidW-1:0]   free_idx;
    logic              any_free;
    logic              can_issue;
    logic              issue;
    logic              ack_hit;

    tag_alloc_prio #(.NrTags(NrTags), .IdxW(TidW)) u_alloc (
        .busy     (busy_q),
        .idx      (free_idx),
        .any_free (any_free)
    );

    // any_free keeps an invalid tag off the bus even if Limit exceeds the tag space.
    assign can_issue = (cnt_q < LimitC) && (state_q == IDLE) && any_free;

    assign bus.mem_valid_o = bus.st_valid_i & can_issue;
    assign bus.st_ready_o  = bus.mem_ready_i & can_issue;
    assign bus.mem_tid_o   = free_idx;

    assign issue   = bus.st_valid_i & bus.st_ready_o;
    // Pre-update busy: an ack to the tag allocated this cycle is a miss.
    assign ack_hit = bus.ack_valid_i & busy_q[bus.ack_tid_i];

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (issue)   busy_d[free_idx]      = 1'b1;
        if (ack_hit) busy_d[bus.ack_tid_i] = 1'b0;
        case ({issue, ack_hit})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.fence_i) state_d = DRAIN;
            DRAIN:   if (cnt_d == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q  <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            err_q   <= bus.ack_valid_i & ~busy_q[bus.ack_tid_i];
        end
    end

    assign bus.outstanding_o = cnt_q;
    assign bus.full_o        = (cnt_q == LimitC);
    assign bus.empty_o       = (cnt_q == '0);
    assign bus.err_o         = err_q;
    assign bus.fence_done_o  = (state_q == DONE);
endmodule

// File: tb/tb_outstanding_store_ctrl.sv
// Directed bench: driver queues expected outputs/tags, negedge monitor checks them.
module tb_outstanding_store_ctrl;
    localparam int S_READY = 0, S_MVALID = 1, S_OUT = 2, S_FULL = 3,
                   S_EMPTY = 4, S_ERR = 5, S_DONE = 6;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   tid_q[$];

    outstanding_store_ctrl_if #(.TidW(2), .CntW(3)) b ();

    outstanding_store_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int get_sig(int s);
        case (s)
            S_READY:  return int'(b.st_ready_o);
            S_MVALID: return int'(b.mem_valid_o);
            S_OUT:    return int'(b.outstanding_o);
            S_FULL:   return int'(b.full_o);
            S_EMPTY:  return int'(b.empty_o);
            S_ERR:    return int'(b.err_o);
            S_DONE:   return int'(b.fence_done_o);
            default:  return -1;
        endcase
    endfunction

    // Monitor: compare scheduled expectations and every accepted store's tag.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                int act;
                act = get_sig(exp_q[i].sig);
                n_chk++;
                if (exp_q[i].cyc < cyc || act != exp_q[i].val) begin
                    n_fail++;
                    $display("FAIL %s: got %0d expected %0d (cycle %0d, due %0d)",
                             exp_q[i].name, act, exp_q[i].val, cyc, exp_q[i].cyc);
                end
                exp_q.delete(i);
            end
        end
        if (b.mem_valid_o && b.mem_ready_i) begin
            n_chk++;
            if (tid_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_issue: got tid %0d expected no issue (cycle %0d)",
                         b.mem_tid_o, cyc);
            end else begin
                int e;
                e = tid_q.pop_front();
                if (int'(b.mem_tid_o) != e) begin
                    n_fail++;
                    $display("FAIL mem_tid: got %0d expected %0d (cycle %0d)", b.mem_tid_o, e, cyc);
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(int d, int s, int v, string n);
        exp_q.push_back('{cyc + d, s, v, n});
    endtask

    task automatic idle_in();
        b.st_valid_i  = 1'b0;
        b.ack_valid_i = 1'b0;
        b.ack_tid_i   = '0;
        b.fence_i     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        nxt();
        rst = 1'b0;
    endtask

    task automatic ack(int t);
        b.ack_valid_i = 1'b1;
        b.ack_tid_i   = 2'(t);
    endtask

    task automatic store(int t);
        b.st_valid_i = 1'b1;
        tid_q.push_back(t);
        ex(0, S_READY, 1, "store_ready");
        nxt();
        b.st_valid_i = 1'b0;
    endtask

    initial begin
        idle_in();
        b.mem_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ex(0, S_OUT, 0, "rst_out");   ex(0, S_EMPTY, 1, "rst_empty");
        ex(0, S_FULL, 0, "rst_full"); ex(0, S_ERR, 0, "rst_err");
        ex(0, S_DONE, 0, "rst_done"); ex(0, S_READY, 1, "rst_ready");
        ex(0, S_MVALID, 0, "rst_mvalid");
        nxt();

        // Fill to the limit, fifth store held off, then free tag 2 and reuse it.
        for (int i = 0; i < 4; i++) store(i);
        b.st_valid_i = 1'b1;
        ex(0, S_FULL, 1, "full_set");    ex(0, S_OUT, 4, "full_out");
        ex(0, S_READY, 0, "full_ready"); ex(0, S_MVALID, 0, "full_mvalid");
        ex(0, S_EMPTY, 0, "full_empty");
        ack(2);
        nxt();
        b.ack_valid_i = 1'b0;
        ex(0, S_OUT, 3, "ack2_out"); ex(0, S_FULL, 0, "ack2_full"); ex(0, S_ERR, 0, "ack2_err");
        store(2);
        ex(0, S_OUT, 4, "refill_out"); ex(0, S_FULL, 1, "refill_full");

        // Same-cycle issue and ack: count holds, busy becomes 0110.
        do_reset();
        ex(0, S_OUT, 0, "rst2_out");
        store(0); store(1);
        b.st_valid_i = 1'b1; tid_q.push_back(2); ack(0);
        nxt();
        idle_in();
        ex(0, S_OUT, 2, "swap_out"); ex(0, S_ERR, 0, "swap_err");
        store(0); store(3);
        ex(0, S_OUT, 4, "swap_fill_out");

        // Ack to the tag being allocated this cycle is a miss.
        ack(3);
        nxt();
        idle_in();
        ex(0, S_OUT, 3, "ack3_out");
        b.st_valid_i = 1'b1; tid_q.push_back(3); ack(3);
        nxt();
        idle_in();
        ex(0, S_ERR, 1, "alloc_ack_err"); ex(0, S_OUT, 4, "alloc_ack_out");
        nxt();
        ex(0, S_ERR, 0, "alloc_ack_err_clr");

        // Fence with three outstanding, acks at +2/+4/+6.
        do_reset();
        store(0); store(1); store(2);
        b.fence_i = 1'b1;
        ex(0, S_READY, 1, "fence_ready"); ex(0, S_OUT, 3, "fence_out");
        nxt();
        b.fence_i = 1'b0; b.st_valid_i = 1'b1;
        ex(0, S_READY, 0, "drain_ready"); ex(0, S_MVALID, 0, "drain_mvalid");
        ex(0, S_DONE, 0, "drain_done1");
        nxt();
        b.st_valid_i = 1'b0; ack(0);
        nxt();
        idle_in(); b.fence_i = 1'b1;
        ex(0, S_OUT, 2, "drain_out2"); ex(0, S_DONE, 0, "drain_done3");
        nxt();
        b.fence_i = 1'b0; ack(1);
        nxt();
        idle_in();
        ex(0, S_DONE, 0, "drain_done5");
        nxt();
        ack(2);
        ex(0, S_DONE, 0, "drain_done6"); ex(0, S_OUT, 1, "drain_out6");
        nxt();
        idle_in(); b.fence_i = 1'b1;
        ex(0, S_DONE, 1, "fence_done"); ex(0, S_OUT, 0, "done_out");
        ex(0, S_READY, 0, "done_ready");
        nxt();
        b.fence_i = 1'b0;
        ex(0, S_DONE, 0, "done_clr"); ex(0, S_READY, 1, "idle_ready");
        ex(0, S_EMPTY, 1, "idle_empty");
        nxt();
        ex(0, S_DONE, 0, "done_refence_ignored"); ex(0, S_READY, 1, "idle_ready2");

        // Empty fence still passes through DRAIN.
        b.fence_i = 1'b1;
        nxt();
        b.fence_i = 1'b0;
        ex(0, S_READY, 0, "efence_ready"); ex(0, S_DONE, 0, "efence_drain");
        nxt();
        ex(0, S_DONE, 1, "efence_done");
        nxt();
        ex(0, S_DONE, 0, "efence_clr"); ex(0, S_READY, 1, "efence_idle");

        // Ack to a non-busy tag while empty.
        ack(3);
        ex(1, S_ERR, 1, "stray_err"); ex(1, S_OUT, 0, "stray_out"); ex(2, S_ERR, 0, "stray_err_clr");
        nxt();
        idle_in();
        nxt(); nxt();

        // Reset mid-drain abandons the fence; pre-reset tags become stray.
        do_reset();
        store(0); store(1);
        b.fence_i = 1'b1;
        nxt();
        b.fence_i = 1'b0;
        ex(0, S_OUT, 2, "mid_out"); ex(0, S_READY, 0, "mid_ready");
        do_reset();
        ex(0, S_OUT, 0, "mrst_out"); ex(0, S_EMPTY, 1, "mrst_empty");
        ex(0, S_DONE, 0, "mrst_done"); ex(0, S_READY, 1, "mrst_ready");
        ex(1, S_DONE, 0, "mrst_done1"); ex(2, S_DONE, 0, "mrst_done2");
        ack(0);
        ex(1, S_ERR, 1, "mrst_stray_err");
        nxt();
        idle_in();
        nxt(); nxt(); nxt();

        n_chk++;
        if (exp_q.size() != 0 || tid_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d/%0d pending expected 0/0", exp_q.size(), tid_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
